// File: rtl/pipelined_vector_sum_pkg.sv
// Shared helpers for the pipelined vector sum.
// Tree geometry functions and the per-stage tag bundle.
package pipelined_vector_sum_pkg;

    typedef struct packed {
        logic valid;
        logic last;
    } tag_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Element count entering tree level k.
    function automatic int level_n(input int dim, input int k);
        int n;
        n = dim;
        for (int i = 0; i < k; i++) n = (n + 1) / 2;
        return n;
    endfunction

    // Element offset of level k on the flat tree bus.
    function automatic int level_off(input int dim, input int k);
        int o;
        o = 0;
        for (int i = 0; i < k; i++) o += level_n(dim, i);
        return o;
    endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered level of the reduction tree.
// Pairs are summed; an odd leftover passes through.
module adder_tree_level
    import pipelined_vector_sum_pkg::*;
#(
    parameter int N_IN = 2,
    parameter int W    = 8
) (
    input  logic                        Clock,
    input  logic                        Reset_n,
    input  logic                        en,
    input  logic                        in_valid,
    input  logic                        in_last,
    input  logic [N_IN*W-1:0]           data,
    output logic                        out_valid,
    output logic                        out_last,
    output logic [((N_IN+1)/2)*W-1:0]   sum
);

    localparam int N_OUT = (N_IN + 1) / 2;

    logic [N_OUT*W-1:0] sum_d;
    tag_t               tag_q;

    for (genvar j = 0; j < N_IN / 2; j++) begin : g_pair
        assign sum_d[j*W +: W] = data[(2*j)*W +: W]
                               + data[(2*j+1)*W +: W];
    end

    if (N_IN % 2 == 1) begin : g_odd
        assign sum_d[(N_OUT-1)*W +: W] = data[(N_IN-1)*W +: W];
    end

    // Register the level's sums and tag while the pipe advances.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            tag_q <= '0;
            sum   <= '0;
        end else if (en) begin
            tag_q <= '{valid: in_valid, last: in_last};
            sum   <= sum_d;
        end
    end

    assign out_valid = tag_q.valid;
    assign out_last  = tag_q.last;

endmodule

// File: rtl/pipelined_vector_sum.sv
// Pipelined adder-tree vector sum with group accumulation.
// Stage 0, tree levels, then accumulator/output register.
module pipelined_vector_sum
    import pipelined_vector_sum_pkg::*;
#(
    parameter  int DIM       = 10,
    parameter  int W_u       = 32,
    parameter  int SIGNED    = 0,
    parameter  int MAX_BEATS = 1,
    localparam int LEVELS    = clog2(DIM),
    localparam int W_S       = W_u + clog2(DIM) + clog2(MAX_BEATS)
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic [DIM*W_u-1:0] u,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    output logic [W_S-1:0]     sum,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int BUS_W = level_off(DIM, LEVELS + 1) * W_S;
    localparam int TOP_O = level_off(DIM, LEVELS) * W_S;

    logic               en;
    logic               init_q;
    logic               take;
    tag_t               s0_tag;
    logic [DIM*W_S-1:0] s0_ext;
    logic [DIM*W_S-1:0] s0_data;
    logic [BUS_W-1:0]   bus;
    logic [LEVELS:0]    lv;
    logic [LEVELS:0]    ll;
    logic [W_S-1:0]     tree_out;
    logic [W_S-1:0]     acc;

    assign en       = !out_valid || out_ready;
    assign in_ready = en && init_q;
    assign take     = in_valid && in_ready;

    // Hold off input acceptance until the first edge after reset.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) init_q <= 1'b0;
        else          init_q <= 1'b1;
    end

    // Extend each element to the full sum width.
    always_comb begin
        s0_ext = '0;
        for (int i = 0; i < DIM; i++) begin
            if (SIGNED != 0)
                s0_ext[i*W_S +: W_S] = W_S'($signed(u[i*W_u +: W_u]));
            else
                s0_ext[i*W_S +: W_S] = W_S'(u[i*W_u +: W_u]);
        end
    end

    // Stage 0: capture the extended vector; single-beat mode forces last.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            s0_tag  <= '0;
            s0_data <= '0;
        end else if (en) begin
            s0_tag  <= '{valid: take,
                         last:  (MAX_BEATS == 1) || in_last};
            s0_data <= s0_ext;
        end
    end

    assign bus[0 +: DIM*W_S] = s0_data;
    assign lv[0]             = s0_tag.valid;
    assign ll[0]             = s0_tag.last;

    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        localparam int NI = level_n(DIM, k);
        localparam int NO = level_n(DIM, k + 1);
        localparam int OI = level_off(DIM, k) * W_S;
        localparam int OO = level_off(DIM, k + 1) * W_S;

        adder_tree_level #(
            .N_IN (NI),
            .W    (W_S)
        ) u_level (
            .Clock     (Clock),
            .Reset_n   (Reset_n),
            .en        (en),
            .in_valid  (lv[k]),
            .in_last   (ll[k]),
            .data      (bus[OI +: NI*W_S]),
            .out_valid (lv[k+1]),
            .out_last  (ll[k+1]),
            .sum       (bus[OO +: NO*W_S])
        );
    end

    assign tree_out = bus[TOP_O +: W_S];

    // Accumulate beats; acc is zero at each group start, last beat emits.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            acc       <= '0;
            sum       <= '0;
            out_valid <= 1'b0;
        end else if (en) begin
            out_valid <= lv[LEVELS] && ll[LEVELS];
            if (lv[LEVELS]) begin
                if (ll[LEVELS]) begin
                    sum <= acc + tree_out;
                    acc <= '0;
                end else begin
                    acc <= acc + tree_out;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_vector_sum.sv
// Randomized self-checking bench for pipelined_vector_sum.
// Three configurations checked against a queue-based model.
module tb_pipelined_vector_sum;

    localparam int DIM = 10;
    localparam int WU  = 8;
    localparam int WSA = 12;
    localparam int WSC = 14;

    logic Clock   = 1'b0;
    logic Reset_n = 1'b0;
    always #5 Clock = ~Clock;

    logic [DIM*WU-1:0] a_u, b_u, c_u;
    logic a_iv, a_il, a_ir, a_ov, a_or;
    logic b_iv, b_il, b_ir, b_ov, b_or;
    logic c_iv, c_il, c_ir, c_ov, c_or;
    logic [WSA-1:0] a_sum, b_sum;
    logic [WSC-1:0] c_sum;

    pipelined_vector_sum #(
        .DIM(DIM), .W_u(WU), .SIGNED(0), .MAX_BEATS(1)
    ) dut_a (
        .Clock(Clock), .Reset_n(Reset_n), .u(a_u),
        .in_valid(a_iv), .in_last(a_il), .in_ready(a_ir),
        .sum(a_sum), .out_valid(a_ov), .out_ready(a_or)
    );

    pipelined_vector_sum #(
        .DIM(DIM), .W_u(WU), .SIGNED(1), .MAX_BEATS(1)
    ) dut_b (
        .Clock(Clock), .Reset_n(Reset_n), .u(b_u),
        .in_valid(b_iv), .in_last(b_il), .in_ready(b_ir),
        .sum(b_sum), .out_valid(b_ov), .out_ready(b_or)
    );

    pipelined_vector_sum #(
        .DIM(DIM), .W_u(WU), .SIGNED(0), .MAX_BEATS(4)
    ) dut_c (
        .Clock(Clock), .Reset_n(Reset_n), .u(c_u),
        .in_valid(c_iv), .in_last(c_il), .in_ready(c_ir),
        .sum(c_sum), .out_valid(c_ov), .out_ready(c_or)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    int qa[$], qa_c[$], qb[$], qc[$], c_hist[$];
    int c_acc = 0;
    int a_outs = 0, b_outs = 0;
    int a_last_sum = -1, a_last_lat = -1, b_last_sum = -1;
    bit lat_on = 0, bp_on = 0, held_v = 0, a_acc = 0;
    logic [WSA-1:0] held;

    task automatic chk(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int vsum(input logic [DIM*WU-1:0] v,
                                input bit sgn);
        int  s;
        byte sb;
        s = 0;
        for (int i = 0; i < DIM; i++) begin
            sb = v[i*WU +: WU];
            s += sgn ? int'(sb) : int'(v[i*WU +: WU]);
        end
        return s;
    endfunction

    function automatic logic [DIM*WU-1:0] rvec();
        logic [DIM*WU-1:0] v;
        for (int i = 0; i < DIM; i++) v[i*WU +: WU] = WU'($urandom);
        return v;
    endfunction

    function automatic logic [DIM*WU-1:0] fill(input int x);
        logic [DIM*WU-1:0] v;
        for (int i = 0; i < DIM; i++) v[i*WU +: WU] = WU'(x);
        return v;
    endfunction

    // Sample this cycle's handshakes, update the model, advance a cycle.
    task automatic tick();
        int e, c0;
        #1;
        a_acc = a_iv && a_ir;
        if (bp_on && a_ov && !a_or) begin
            if (!held_v) begin
                held   = a_sum;
                held_v = 1;
            end else begin
                chk("bp_hold", a_sum, held);
            end
            chk("bp_ready", a_ir, 0);
        end
        if (a_iv && a_ir) begin
            qa.push_back(vsum(a_u, 0) & 'hFFF);
            qa_c.push_back(cyc);
        end
        if (a_ov && a_or) begin
            chk("a_expected", qa.size() > 0, 1);
            if (qa.size() > 0) begin
                e  = qa.pop_front();
                c0 = qa_c.pop_front();
                chk("a_sum", a_sum, e);
                a_last_sum = a_sum;
                a_last_lat = cyc - c0;
                if (lat_on) chk("a_latency", cyc - c0, 6);
            end
            a_outs++;
        end
        if (b_iv && b_ir) qb.push_back(vsum(b_u, 1) & 'hFFF);
        if (b_ov && b_or) begin
            chk("b_expected", qb.size() > 0, 1);
            if (qb.size() > 0) chk("b_sum", b_sum, qb.pop_front());
            b_last_sum = b_sum;
            b_outs++;
        end
        if (c_iv && c_ir) begin
            c_acc += vsum(c_u, 0);
            if (c_il) begin
                qc.push_back(c_acc & 'h3FFF);
                c_acc = 0;
            end
        end
        if (c_ov && c_or) begin
            chk("c_expected", qc.size() > 0, 1);
            if (qc.size() > 0) chk("c_sum", c_sum, qc.pop_front());
            c_hist.push_back(c_sum);
        end
        cyc++;
        @(negedge Clock);
    endtask

    initial begin
        int beats, sent, t, base;
        a_u = '0; b_u = '0; c_u = '0;
        a_iv = 0; b_iv = 0; c_iv = 0;
        a_il = 0; b_il = 0; c_il = 0;
        a_or = 1; b_or = 1; c_or = 1;

        @(negedge Clock);
        chk("rst_out_valid", a_ov, 0);
        chk("rst_sum", a_sum, 0);
        chk("rst_c_sum", c_sum, 0);
        chk("rst_in_ready", a_ir, 0);
        Reset_n = 1;
        #1 chk("ready_before_edge", a_ir, 0);
        @(posedge Clock);
        #1 chk("ready_after_edge", a_ir, 1);
        @(negedge Clock);

        // Elements 1..10 give 55 with the nominal latency.
        lat_on = 1;
        for (int i = 0; i < DIM; i++) a_u[i*WU +: WU] = WU'(i + 1);
        a_iv = 1;
        tick();
        a_iv = 0;
        repeat (12) tick();
        chk("t1_sum", a_last_sum, 55);
        chk("t1_latency", a_last_lat, 6);
        chk("t1_count", a_outs, 1);

        // Back-to-back random streams on all three instances.
        beats = 0;
        for (int i = 0; i < 20; i++) begin
            a_u = rvec(); a_iv = 1;
            b_u = rvec(); b_iv = 1;
            c_u = rvec(); c_iv = 1;
            beats++;
            c_il = (beats == 4) || ($urandom_range(0, 2) == 0) || (i == 19);
            if (c_il) beats = 0;
            tick();
        end
        a_iv = 0; b_iv = 0; c_iv = 0; c_il = 0;
        repeat (12) tick();
        chk("t2_a_drained", qa.size(), 0);
        chk("t2_a_count", a_outs, 21);
        chk("t2_b_drained", qb.size(), 0);
        chk("t2_c_drained", qc.size(), 0);
        lat_on = 0;

        // Output held off for 8 cycles mid-stream.
        bp_on = 1; held_v = 0;
        base = a_outs;
        sent = 0; t = 0;
        while (sent < 30 && t < 200) begin
            a_or = !(t >= 10 && t < 18);
            if (!a_iv) begin
                a_iv = 1;
                a_u  = rvec();
            end
            tick();
            if (a_acc) begin
                sent++;
                a_iv = 0;
            end
            t++;
        end
        a_iv = 0; a_or = 1; bp_on = 0;
        repeat (12) tick();
        chk("t3_sent", sent, 30);
        chk("t3_held_seen", held_v, 1);
        chk("t3_drained", qa.size(), 0);
        chk("t3_count", a_outs - base, 30);

        // Signed: every element -128.
        b_u = fill(8'h80); b_iv = 1;
        tick();
        b_iv = 0;
        repeat (10) tick();
        chk("t4_signed_sum", b_last_sum, 'hB00);

        // Three-beat group then a single-beat group.
        c_hist.delete();
        c_iv = 1;
        c_u = fill(1); c_il = 0; tick();
        c_u = fill(2); c_il = 0; tick();
        c_u = fill(3); c_il = 1; tick();
        c_u = fill(1); c_il = 1; tick();
        c_iv = 0; c_il = 0;
        repeat (10) tick();
        chk("t5_count", c_hist.size(), 2);
        if (c_hist.size() >= 2) begin
            chk("t5_group_sum", c_hist[0], 60);
            chk("t5_single_sum", c_hist[1], 10);
        end

        // Reset with work in flight and a partial group.
        a_or = 0;
        a_iv = 1;
        c_iv = 1; c_il = 0;
        for (int i = 0; i < 3; i++) begin
            a_u = rvec();
            c_u = rvec();
            c_iv = (i < 2);
            tick();
        end
        a_iv = 0; c_iv = 0;
        t = 0;
        while (!a_ov && t < 20) begin
            tick();
            t++;
        end
        chk("t6_filled", a_ov, 1);
        #2 Reset_n = 0;
        #1;
        chk("t6_rst_valid", a_ov, 0);
        chk("t6_rst_sum", a_sum, 0);
        chk("t6_rst_c_valid", c_ov, 0);
        qa.delete(); qa_c.delete(); qc.delete();
        c_acc = 0;
        c_hist.delete();
        @(negedge Clock);
        @(negedge Clock);
        Reset_n = 1;
        @(negedge Clock);
        a_or = 1;
        base = a_outs;
        a_u = fill(1); a_iv = 1;
        c_u = fill(1); c_iv = 1; c_il = 1;
        tick();
        a_iv = 0; c_iv = 0; c_il = 0;
        repeat (14) tick();
        chk("t6_a_count", a_outs - base, 1);
        chk("t6_a_sum", a_last_sum, 10);
        chk("t6_c_count", c_hist.size(), 1);
        if (c_hist.size() >= 1) chk("t6_c_sum", c_hist[0], 10);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
